// File: rtl/signal_monitor.sv
// -----------------------------------------------------------------------------
// signal_monitor
//
// Conflict monitor for a four-way traffic signal. The lamp codes of the four
// approaches are sampled on every clock edge and checked for legal codes,
// conflicting non-red directions, dark lamps, illegal per-direction sequences,
// a green phase held too long and an all-red gap held too long. The first
// violation is latched together with its cause, and the fail-safe flasher
// output starts toggling until the fault is cleared.
//
// Parameters
//   MAX_GREEN   maximum consecutive green samples for one direction
//   MAX_ALLRED  maximum consecutive all-red samples while running
//   FLASH_HALF  half-period of the flash output, in clk cycles
//
// Ports
//   clk          clock, all logic on the rising edge
//   rst          synchronous active-high reset, dominates every other input
//   N, E, S, W   lamp codes: 100 red, 001 yellow, 010 green, 000 dark
//   clr_fault    clears a latched fault (only acted on while faulted)
//   fault        latched fault flag
//   fault_code   cause of the first fault:
//                1 INVALID, 2 CONFLICT, 3 DARK, 4 SEQUENCE, 5 STUCK, 6 GAP
//   flash        fail-safe flasher drive
//   active_dir   index of the non-red direction (0=N, 1=E, 2=S, 3=W)
//   serve_count  number of completed green phases (wraps 255 -> 0)
// -----------------------------------------------------------------------------
module signal_monitor #(
  parameter int MAX_GREEN  = 16,
  parameter int MAX_ALLRED = 4,
  parameter int FLASH_HALF = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] N,
  input  logic [2:0] E,
  input  logic [2:0] S,
  input  logic [2:0] W,
  input  logic       clr_fault,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash,
  output logic [1:0] active_dir,
  output logic [7:0] serve_count
);

  localparam int GW = $clog2(MAX_GREEN + 1);
  localparam int AW = $clog2(MAX_ALLRED + 1);
  localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

  localparam logic [2:0] L_RED  = 3'b100;
  localparam logic [2:0] L_YEL  = 3'b001;
  localparam logic [2:0] L_GRN  = 3'b010;
  localparam logic [2:0] L_DARK = 3'b000;

  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_INVALID  = 3'd1;
  localparam logic [2:0] FC_CONFLICT = 3'd2;
  localparam logic [2:0] FC_DARK     = 3'd3;
  localparam logic [2:0] FC_SEQUENCE = 3'd4;
  localparam logic [2:0] FC_STUCK    = 3'd5;
  localparam logic [2:0] FC_GAP      = 3'd6;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  state_t          r_state;
  logic [2:0]      r_prev [4];
  logic [1:0]      r_exp_dir;
  logic [GW-1:0]   r_green_cnt;
  logic [AW-1:0]   r_allred_cnt;
  logic            r_fault;
  logic [2:0]      r_fault_code;
  logic            r_flash;
  logic [FW-1:0]   r_flash_div;
  logic [1:0]      r_active_dir;
  logic [7:0]      r_serve_count;

  state_t          w_state_next;
  logic [2:0]      w_prev_next [4];
  logic [1:0]      w_exp_dir_next;
  logic [GW-1:0]   w_green_cnt_next;
  logic [AW-1:0]   w_allred_cnt_next;
  logic            w_fault_next;
  logic [2:0]      w_fault_code_next;
  logic            w_flash_next;
  logic [FW-1:0]   w_flash_div_next;
  logic [1:0]      w_active_dir_next;
  logic [7:0]      w_serve_count_next;

  // ---------------------------------------------------------------------------
  // Per-direction decode
  // ---------------------------------------------------------------------------
  logic [2:0] w_lamp [4];
  logic [2:0] w_ref  [4];
  logic [3:0] w_is_red;
  logic [3:0] w_is_yel;
  logic [3:0] w_is_grn;
  logic [3:0] w_is_dark;
  logic [3:0] w_valid;
  logic [3:0] w_seq_ok;
  logic [3:0] w_g2r;
  logic [3:0] w_nonred;

  assign w_lamp[0] = N;
  assign w_lamp[1] = E;
  assign w_lamp[2] = S;
  assign w_lamp[3] = W;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dir
    // The first non-dark sample out of INIT is judged against an all-red
    // history, so the reference lamp is forced red outside RUN.
    assign w_ref[gi]     = (r_state == S_RUN) ? r_prev[gi] : L_RED;

    assign w_is_red[gi]  = (w_lamp[gi] == L_RED);
    assign w_is_yel[gi]  = (w_lamp[gi] == L_YEL);
    assign w_is_grn[gi]  = (w_lamp[gi] == L_GRN);
    assign w_is_dark[gi] = (w_lamp[gi] == L_DARK);
    assign w_valid[gi]   = w_is_red[gi] | w_is_yel[gi] | w_is_grn[gi] | w_is_dark[gi];
    assign w_nonred[gi]  = ~w_is_red[gi];

    // Only the direction due next may leave red.
    assign w_seq_ok[gi] =
        (w_ref[gi] == L_RED) ? (w_is_red[gi] || (w_is_yel[gi] && (r_exp_dir == 2'(gi)))) :
        (w_ref[gi] == L_YEL) ? (w_is_yel[gi] || w_is_grn[gi]) :
        (w_ref[gi] == L_GRN) ? (w_is_grn[gi] || w_is_red[gi]) :
                               1'b0;

    assign w_g2r[gi] = (w_ref[gi] == L_GRN) && w_is_red[gi];
  end

  // ---------------------------------------------------------------------------
  // Whole-sample checks
  // ---------------------------------------------------------------------------
  logic       w_any_invalid;
  logic       w_conflict;
  logic       w_any_dark;
  logic       w_all_dark;
  logic       w_seq_err;
  logic       w_any_green;
  logic       w_all_red;
  logic       w_stuck;
  logic       w_gap;
  logic [2:0] w_run_code;
  logic [1:0] w_nonred_idx;

  assign w_any_invalid = ~&w_valid;
  // More than one bit set: clearing the lowest set bit leaves something.
  assign w_conflict    = |(w_nonred & (w_nonred - 4'd1));
  assign w_any_dark    = |w_is_dark;
  assign w_all_dark    = &w_is_dark;
  assign w_seq_err     = ~&w_seq_ok;
  assign w_any_green   = |w_is_grn;
  assign w_all_red     = &w_is_red;
  // The counters hold the number of earlier consecutive samples, so the
  // sample that would push them past the limit is the offending one.
  assign w_stuck       = w_any_green && (r_green_cnt == GW'(MAX_GREEN));
  assign w_gap         = w_all_red && (r_allred_cnt == AW'(MAX_ALLRED));

  always_comb begin
    w_run_code = FC_NONE;
    if (w_any_invalid)      w_run_code = FC_INVALID;
    else if (w_conflict)    w_run_code = FC_CONFLICT;
    else if (w_any_dark)    w_run_code = FC_DARK;
    else if (w_seq_err)     w_run_code = FC_SEQUENCE;
    else if (w_stuck)       w_run_code = FC_STUCK;
    else if (w_gap)         w_run_code = FC_GAP;
  end

  // Index of the non-red direction; only used when exactly one is non-red.
  always_comb begin
    w_nonred_idx = r_active_dir;
    for (int i = 3; i >= 0; i--) begin
      if (w_nonred[i]) w_nonred_idx = 2'(i);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic       w_do_fault;
  logic [2:0] w_cause;
  logic       w_accept;

  always_comb begin
    w_state_next       = r_state;
    w_exp_dir_next     = r_exp_dir;
    w_green_cnt_next   = r_green_cnt;
    w_allred_cnt_next  = r_allred_cnt;
    w_fault_next       = r_fault;
    w_fault_code_next  = r_fault_code;
    w_flash_next       = r_flash;
    w_flash_div_next   = r_flash_div;
    w_active_dir_next  = r_active_dir;
    w_serve_count_next = r_serve_count;
    for (int i = 0; i < 4; i++) w_prev_next[i] = r_prev[i];
    w_do_fault = 1'b0;
    w_cause    = FC_NONE;
    w_accept   = 1'b0;

    case (r_state)
      S_INIT: begin
        // All-dark is the legal power-up condition; a partially lit head
        // is a dark fault regardless of what the lit lamps show.
        if (w_any_dark) begin
          w_do_fault = ~w_all_dark;
          w_cause    = FC_DARK;
        end else if (w_run_code != FC_NONE) begin
          w_do_fault = 1'b1;
          w_cause    = w_run_code;
        end else begin
          w_accept = 1'b1;
        end
      end

      S_RUN: begin
        if (w_run_code != FC_NONE) begin
          w_do_fault = 1'b1;
          w_cause    = w_run_code;
        end else begin
          w_accept = 1'b1;
        end
      end

      S_FAULT: begin
        if (r_flash_div == FW'(FLASH_HALF - 1)) begin
          w_flash_next     = ~r_flash;
          w_flash_div_next = '0;
        end else begin
          w_flash_div_next = r_flash_div + 1'b1;
        end
        // serve_count and active_dir are deliberately left untouched.
        if (clr_fault) begin
          w_state_next      = S_INIT;
          w_fault_next      = 1'b0;
          w_fault_code_next = FC_NONE;
          w_flash_next      = 1'b0;
          w_flash_div_next  = '0;
          w_green_cnt_next  = '0;
          w_allred_cnt_next = '0;
          w_exp_dir_next    = 2'd0;
          for (int i = 0; i < 4; i++) w_prev_next[i] = L_RED;
        end
      end

      default: begin
        w_state_next = S_INIT;
      end
    endcase

    // A faulting sample updates nothing but the fault latch and flasher.
    if (w_do_fault) begin
      w_state_next      = S_FAULT;
      w_fault_next      = 1'b1;
      w_fault_code_next = w_cause;
      w_flash_next      = 1'b1;
      w_flash_div_next  = '0;
    end

    if (w_accept) begin
      w_state_next      = S_RUN;
      for (int i = 0; i < 4; i++) w_prev_next[i] = w_lamp[i];
      w_green_cnt_next  = w_any_green ? (r_green_cnt + 1'b1) : '0;
      w_allred_cnt_next = w_all_red ? (r_allred_cnt + 1'b1) : '0;
      if (|w_nonred) w_active_dir_next = w_nonred_idx;
      if (|w_g2r) begin
        w_serve_count_next = r_serve_count + 8'd1;
        w_exp_dir_next     = r_exp_dir + 2'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_INIT;
      r_exp_dir     <= 2'd0;
      r_green_cnt   <= '0;
      r_allred_cnt  <= '0;
      r_fault       <= 1'b0;
      r_fault_code  <= FC_NONE;
      r_flash       <= 1'b0;
      r_flash_div   <= '0;
      r_active_dir  <= 2'd0;
      r_serve_count <= 8'd0;
      for (int i = 0; i < 4; i++) r_prev[i] <= L_RED;
    end else begin
      r_state       <= w_state_next;
      r_exp_dir     <= w_exp_dir_next;
      r_green_cnt   <= w_green_cnt_next;
      r_allred_cnt  <= w_allred_cnt_next;
      r_fault       <= w_fault_next;
      r_fault_code  <= w_fault_code_next;
      r_flash       <= w_flash_next;
      r_flash_div   <= w_flash_div_next;
      r_active_dir  <= w_active_dir_next;
      r_serve_count <= w_serve_count_next;
      for (int i = 0; i < 4; i++) r_prev[i] <= w_prev_next[i];
    end
  end

  assign fault       = r_fault;
  assign fault_code  = r_fault_code;
  assign flash       = r_flash;
  assign active_dir  = r_active_dir;
  assign serve_count = r_serve_count;

endmodule

// File: tb/tb_signal_monitor.sv
// -----------------------------------------------------------------------------
// tb_signal_monitor
//
// Self-checking bench for signal_monitor with default parameters
// (MAX_GREEN=16, MAX_ALLRED=4, FLASH_HALF=2). Stimulus code pushes the
// expected outputs for each checked sample into a queue; a monitor step
// records the DUT outputs one edge later, and each scenario task drains
// and compares both queues.
// -----------------------------------------------------------------------------
module tb_signal_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b001;
  localparam logic [2:0] G = 3'b010;
  localparam logic [2:0] D = 3'b000;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] N, E, S, W;
  logic       clr_fault;
  logic       fault;
  logic [2:0] fault_code;
  logic       flash;
  logic [1:0] active_dir;
  logic [7:0] serve_count;

  typedef struct packed {
    logic       f;
    logic [2:0] code;
    logic       fl;
    logic [1:0] dir;
    logic [7:0] cnt;
  } obs_t;

  obs_t exp_q [$];
  obs_t obs_q [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  signal_monitor #(
    .MAX_GREEN (16),
    .MAX_ALLRED(4),
    .FLASH_HALF(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .N          (N),
    .E          (E),
    .S          (S),
    .W          (W),
    .clr_fault  (clr_fault),
    .fault      (fault),
    .fault_code (fault_code),
    .flash      (flash),
    .active_dir (active_dir),
    .serve_count(serve_count)
  );

  function automatic obs_t mk(input logic f, input logic [2:0] code, input logic fl,
                              input int dir, input int cnt);
    obs_t v;
    v.f    = f;
    v.code = code;
    v.fl   = fl;
    v.dir  = 2'(dir);
    v.cnt  = 8'(cnt);
    return v;
  endfunction

  function automatic string fmt(input obs_t v);
    return $sformatf("fault=%0b code=%0d flash=%0b dir=%0d serve=%0d",
                     v.f, v.code, v.fl, v.dir, v.cnt);
  endfunction

  // All red except direction d, which shows lamp code c. Order {N,E,S,W}.
  function automatic logic [11:0] one(input int d, input logic [2:0] c);
    logic [11:0] v;
    v = {R, R, R, R};
    v[(3 - d) * 3 +: 3] = c;
    return v;
  endfunction

  function automatic logic [11:0] allred();
    return {R, R, R, R};
  endfunction

  // Drive one sample and let it be clocked in; outputs are stable at return.
  task automatic step(input logic [11:0] l, input logic c, input logic r);
    {N, E, S, W} = l;
    clr_fault    = c;
    rst          = r;
    @(posedge clk);
    #1;
  endtask

  // Same, with an expectation for the outputs produced by this sample.
  task automatic stepx(input logic [11:0] l, input logic c, input logic r, input obs_t e);
    exp_q.push_back(e);
    step(l, c, r);
    obs_q.push_back({fault, fault_code, flash, active_dir, serve_count});
  endtask

  // Reset, then one all-red sample: monitor is in RUN expecting N.
  task automatic go_run();
    step(allred(), 1'b0, 1'b1);
    step(allred(), 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    obs_t e, o;
    stepx({G, G, Y, 3'b111}, 1'b1, 1'b1, mk(0, 0, 0, 0, 0));
    stepx({D, R, D, R}, 1'b1, 1'b1, mk(0, 0, 0, 0, 0));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset: got %s, need %s", fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_legal();
    obs_t e, o;
    int   serve;
    int   k;
    serve = 0;
    step(allred(), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) stepx({D, D, D, D}, 1'b0, 1'b0, mk(0, 0, 0, 0, 0));
    for (int rep = 0; rep < 2; rep++) begin
      for (int d = 0; d < 4; d++) begin
        for (int i = 0; i < 2; i++) stepx(one(d, Y), 1'b0, 1'b0, mk(0, 0, 0, d, serve));
        for (int i = 0; i < 5; i++) stepx(one(d, G), 1'b0, 1'b0, mk(0, 0, 0, d, serve));
        serve++;
        for (int i = 0; i < 2; i++) stepx(allred(), 1'b0, 1'b0, mk(0, 0, 0, d, serve));
      end
    end
    k = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL legal[%0d]: got %s, need %s", k, fmt(o), fmt(e));
      end
      k++;
    end
  endtask

  task automatic test_conflict();
    obs_t e, o;
    int   k;
    go_run();
    stepx({G, G, R, R}, 1'b0, 1'b0, mk(1, 2, 1, 0, 0));
    // Lamps are ignored while faulted; flash runs 1,1,0,0,1.
    for (int i = 1; i <= 4; i++)
      stepx({Y, D, G, 3'b111}, 1'b0, 1'b0, mk(1, 2, ((i / 2) % 2) == 0, 0, 0));
    k = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL conflict[%0d]: got %s, need %s", k, fmt(o), fmt(e));
      end
      k++;
    end
  endtask

  task automatic test_invalid_prio();
    obs_t e, o;
    int   k;
    go_run();
    stepx({G, G, 3'b011, R}, 1'b0, 1'b0, mk(1, 1, 1, 0, 0));
    stepx({D, D, D, D}, 1'b0, 1'b0, mk(1, 1, 1, 0, 0));
    stepx({G, G, R, R}, 1'b0, 1'b0, mk(1, 1, 0, 0, 0));
    k = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL invalid_prio[%0d]: got %s, need %s", k, fmt(o), fmt(e));
      end
      k++;
    end
  endtask

  task automatic test_sequence();
    obs_t e, o;
    int   k;
    go_run();
    stepx(one(1, Y), 1'b0, 1'b0, mk(1, 4, 1, 0, 0));
    go_run();
    stepx(one(0, G), 1'b0, 1'b0, mk(1, 4, 1, 0, 0));
    k = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL sequence[%0d]: got %s, need %s", k, fmt(o), fmt(e));
      end
      k++;
    end
  endtask

  task automatic test_stuck_gap();
    obs_t e, o;
    int   k;
    go_run();
    stepx(one(0, Y), 1'b0, 1'b0, mk(0, 0, 0, 0, 0));
    for (int i = 0; i < 16; i++) stepx(one(0, G), 1'b0, 1'b0, mk(0, 0, 0, 0, 0));
    stepx(one(0, G), 1'b0, 1'b0, mk(1, 5, 1, 0, 0));
    go_run();
    stepx(one(0, Y), 1'b0, 1'b0, mk(0, 0, 0, 0, 0));
    stepx(one(0, G), 1'b0, 1'b0, mk(0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) stepx(allred(), 1'b0, 1'b0, mk(0, 0, 0, 0, 1));
    stepx(allred(), 1'b0, 1'b0, mk(1, 6, 1, 0, 1));
    k = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL stuck_gap[%0d]: got %s, need %s", k, fmt(o), fmt(e));
      end
      k++;
    end
  endtask

  task automatic test_clear_reset();
    obs_t e, o;
    int   k;
    // Fault with one phase served, then rst+clr together: everything clears.
    go_run();
    step(one(0, Y), 1'b0, 1'b0);
    step(one(0, G), 1'b0, 1'b0);
    step(allred(), 1'b0, 1'b0);
    stepx({G, G, R, R}, 1'b0, 1'b0, mk(1, 2, 1, 0, 1));
    stepx(allred(), 1'b1, 1'b1, mk(0, 0, 0, 0, 0));
    // Same again, clr alone: back to INIT, serve_count kept.
    step(allred(), 1'b0, 1'b0);
    step(one(0, Y), 1'b0, 1'b0);
    step(one(0, G), 1'b0, 1'b0);
    step(allred(), 1'b0, 1'b0);
    stepx({G, G, R, R}, 1'b0, 1'b0, mk(1, 2, 1, 0, 1));
    stepx(allred(), 1'b1, 1'b0, mk(0, 0, 0, 0, 1));
    // All dark is only legal in INIT.
    stepx({D, D, D, D}, 1'b0, 1'b0, mk(0, 0, 0, 0, 1));
    // Expected direction went back to N, and clr in RUN does nothing.
    stepx(one(0, Y), 1'b1, 1'b0, mk(0, 0, 0, 0, 1));
    stepx(one(0, Y), 1'b1, 1'b0, mk(0, 0, 0, 0, 1));
    // Reset mid-RUN; the following N green is judged against red history.
    stepx(one(0, G), 1'b0, 1'b1, mk(0, 0, 0, 0, 0));
    stepx(one(0, G), 1'b0, 1'b0, mk(1, 4, 1, 0, 0));
    // Partially dark head in INIT.
    stepx(allred(), 1'b0, 1'b1, mk(0, 0, 0, 0, 0));
    stepx({R, D, D, D}, 1'b0, 1'b0, mk(1, 3, 1, 0, 0));
    k = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL clear_reset[%0d]: got %s, need %s", k, fmt(o), fmt(e));
      end
      k++;
    end
  endtask

  task automatic test_wrap();
    obs_t e, o;
    int   k;
    step(allred(), 1'b0, 1'b1);
    for (int p = 0; p < 257; p++) begin
      step(one(p % 4, Y), 1'b0, 1'b0);
      step(one(p % 4, G), 1'b0, 1'b0);
      stepx(allred(), 1'b0, 1'b0, mk(0, 0, 0, p % 4, (p + 1) % 256));
    end
    k = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got %s, need %s", k, fmt(o), fmt(e));
      end
      k++;
    end
  endtask

  initial begin
    {N, E, S, W} = {R, R, R, R};
    clr_fault    = 1'b0;
    rst          = 1'b1;
    test_reset();
    test_legal();
    test_conflict();
    test_invalid_prio();
    test_sequence();
    test_stuck_gap();
    test_clear_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no completion, need completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/signal_monitor.md
SIGNAL_MONITOR -- requirements
Module: signal_monitor

Interface
REQ-001 SHALL have parameter MAX_GREEN, default 16: maximum consecutive green samples for one direction.
REQ-002 SHALL have parameter MAX_ALLRED, default 4: maximum consecutive all-red samples while running.
REQ-003 SHALL have parameter FLASH_HALF, default 2: half-period of the flash output, in clk cycles.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have ports N, E, S, W, input, 3 each: monitored lamp codes (100 red, 001 yellow, 010 green, 000 dark).
REQ-007 SHALL have port clr_fault, input, 1: clears a latched fault.
REQ-008 SHALL have port fault, output, 1: latched fault flag.
REQ-009 SHALL have port fault_code, output, 3: cause of the first fault.
REQ-010 SHALL have port flash, output, 1: fail-safe flasher drive.
REQ-011 SHALL have port active_dir, output, 2: index of the non-red direction (0=N, 1=E, 2=S, 3=W).
REQ-012 SHALL have port serve_count, output, 8: number of completed green phases.

Function
REQ-013 SHALL sample N/E/S/W every clk edge; fault/fault_code SHALL update on the edge that samples the offending value, visible 1 cycle later.
REQ-014 SHALL implement FSM states INIT, RUN and FAULT.
REQ-015 INIT: all-dark samples SHALL be legal; a mixed dark/non-dark sample SHALL fault with code 3 (DARK).
REQ-016 INIT: the first all-non-dark sample SHALL enter RUN with expected direction = N, checked as if the previous sample was all-red.
REQ-017 RUN: any code outside {000,001,010,100} SHALL fault with code 1 (INVALID).
REQ-018 RUN: more than one direction non-red in the same sample SHALL fault with code 2 (CONFLICT).
REQ-019 RUN: any 000 sample SHALL fault with code 3 (DARK).
REQ-020 RUN: the legal per-direction transitions SHALL be red->red, yellow->yellow, yellow->green, green->green and green->red.
REQ-021 RUN: red->yellow SHALL be legal only for the expected direction.
REQ-022 RUN: every other per-direction transition SHALL fault with code 4 (SEQUENCE).
REQ-023 A green->red transition SHALL increment serve_count, wrapping 255->0, and advance the expected direction N->E->S->W->N.
REQ-024 The green counter SHALL clear on any non-green sample of the active direction; the (MAX_GREEN+1)th consecutive green sample SHALL fault with code 5 (STUCK).
REQ-025 The all-red counter SHALL clear on any non-all-red sample; the (MAX_ALLRED+1)th consecutive all-red sample in RUN SHALL fault with code 6 (GAP).
REQ-026 Simultaneous violations SHALL report the lowest code (priority 1>2>3>4>5>6).
REQ-027 Only the first fault SHALL be latched; later violations SHALL not change fault_code.
REQ-028 FAULT: fault SHALL be 1; flash SHALL start at 1 and toggle every FLASH_HALF cycles.
REQ-029 FAULT: serve_count and active_dir SHALL freeze; lamp inputs SHALL be ignored.
REQ-030 clr_fault in FAULT SHALL go to INIT next cycle and clear fault, fault_code, flash, both counters and the expected direction; serve_count SHALL be kept.
REQ-031 clr_fault SHALL be ignored in INIT and RUN.
REQ-032 In RUN, active_dir SHALL show the index of the single non-red direction and hold its last value while all lamps are red.
REQ-033 In INIT, flash SHALL be 0.

Reset
REQ-034 rst SHALL dominate clr_fault and every other input.
REQ-035 rst SHALL force INIT with fault=0, fault_code=0, flash=0, active_dir=0 and serve_count=0.
REQ-036 rst SHALL clear the green counter, the all-red counter, the flash divider and the expected direction (to N).
REQ-037 rst asserted mid-RUN or in FAULT SHALL take effect on the next edge with no residual state.

Verification
REQ-038 Scenario LEGAL: rst, 3 dark cycles, then 2 full N-E-S-W cycles (yellow 2 cycles, green 5, all-red 2) -> fault=0, serve_count=8, active_dir follows 0,1,2,3.
REQ-039 Scenario CONFLICT: in RUN, N=010 and E=010 in the same sample -> next cycle fault=1, fault_code=2; flash pattern 1,1,0,0,1.
REQ-040 Scenario INVALID+PRIO: S=011 and a conflict in the same sample -> fault_code=1; a later violation leaves the code at 1.
REQ-041 Scenario SEQUENCE: expected N, E goes 100->001 -> fault_code=4; separately, N goes 100->010 -> fault_code=4.
REQ-042 Scenario STUCK/GAP: N green for 17 samples (MAX_GREEN=16) -> fault_code=5; 5 consecutive all-red samples in RUN -> fault_code=6.
REQ-043 Scenario CLEAR/RESET: clr_fault with rst both high in FAULT -> serve_count=0; clr_fault alone -> INIT, serve_count kept; clr_fault in RUN -> no effect.
